// File: rtl/mux_scan.sv
// mux_scan: registered channel multiplexer with manual select and auto scan.
//
// Selects one WIDTH-bit slice of data_in and registers it on out. The channel
// register ch is set directly from sel (manual mode). In the auto modes it
// steps up or down once every dwell+1 cycles, or freezes (hold mode) while out
// keeps re-sampling the held channel.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   data_in  CHANNELS*WIDTH packed channels, channel i at [i*WIDTH +: WIDTH]
//   sel      manual channel select / auto-mode load value
//   mode     00 manual, 01 auto-up, 10 auto-down, 11 hold
//   dwell    extra cycles spent on each channel in the auto modes
//   load     auto modes only: load sel into ch
//   out      registered data of the channel ch moves to (1-cycle latency)
//   ch       current channel register
//   valid    out holds a post-reset sample
//   wrap     one-cycle pulse after an auto advance crosses the channel boundary
//   err      one-cycle pulse after an out-of-range select or load value
//
// 2**SEL_W must be >= CHANNELS. Unused select codes map to zero padding.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                mode,
  input  logic [7:0]                dwell,
  input  logic                      load,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap,
  output logic                      err
);

  localparam logic [1:0] MODE_MAN  = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam int              NSLOT   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  logic [NSLOT-1:0][WIDTH-1:0] chan;
  logic [7:0]       dcnt, dcnt_eff, dcnt_nxt;
  logic [1:0]       prev_mode;
  logic [SEL_W-1:0] ch_nxt;
  logic             sel_ok, mode_chg, hold_out, wrap_nxt, err_nxt;

  // Unpack the channels into a select-sized table; codes past CHANNELS read 0.
  for (genvar i = 0; i < NSLOT; i++) begin : g_chan
    if (i < CHANNELS) begin : g_live
      assign chan[i] = data_in[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[i] = '0;
    end
  end

  assign sel_ok   = (32'(sel) < CHANNELS);
  assign mode_chg = (mode != prev_mode);
  // A mode change restarts the dwell count on this very edge: the new mode's
  // rule is evaluated as if the count were already 0.
  assign dcnt_eff = mode_chg ? 8'd0 : dcnt;

  always_comb begin
    ch_nxt   = ch;
    dcnt_nxt = dcnt_eff;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    hold_out = 1'b0;
    case (mode)
      MODE_MAN: begin
        if (sel_ok) begin
          ch_nxt   = sel;
          dcnt_nxt = 8'd0;
        end else begin
          // Bad manual select: keep channel and last sample, flag it.
          err_nxt  = 1'b1;
          hold_out = 1'b1;
        end
      end
      MODE_UP, MODE_DN: begin
        if (load && sel_ok) begin
          // Load wins over advance and never reports a wrap.
          ch_nxt   = sel;
          dcnt_nxt = 8'd0;
        end else begin
          err_nxt = load;
          if (dcnt_eff == dwell) begin
            dcnt_nxt = 8'd0;
            if (mode == MODE_UP) begin
              if (ch == CH_LAST) begin
                ch_nxt   = '0;
                wrap_nxt = 1'b1;
              end else begin
                ch_nxt = ch + SEL_W'(1);
              end
            end else begin
              if (ch == '0) begin
                ch_nxt   = CH_LAST;
                wrap_nxt = 1'b1;
              end else begin
                ch_nxt = ch - SEL_W'(1);
              end
            end
          end else begin
            // Free-running 8-bit count: if dwell dropped below the count it
            // rolls through 255 back to 0 before it can match again.
            dcnt_nxt = dcnt_eff + 8'd1;
          end
        end
      end
      default: ; // hold: ch and count frozen, out still re-samples ch
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch        <= '0;
      dcnt      <= '0;
      prev_mode <= MODE_MAN;
      out       <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ch        <= ch_nxt;
      dcnt      <= dcnt_nxt;
      prev_mode <= mode;
      valid     <= 1'b1;
      wrap      <= wrap_nxt;
      err       <= err_nxt;
      if (!hold_out) out <= chan[ch_nxt];
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan at WIDTH=4, CHANNELS=12, SEL_W=4 (select codes 12..15
// are out of range). A behavioural model advanced on the clock is compared
// with the DUT every cycle; directed sections add literal expectations.
module tb_mux_scan;
  localparam int W  = 4;
  localparam int CH = 12;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH*W-1:0] din;
  logic [SW-1:0]   sel;
  logic [1:0]      mode;
  logic [7:0]      dwell;
  logic            load;
  logic [W-1:0]    dout;
  logic [SW-1:0]   dch;
  logic            dvalid, dwrap, derr;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mux_scan #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .data_in(din), .sel(sel), .mode(mode),
    .dwell(dwell), .load(load), .out(dout), .ch(dch), .valid(dvalid),
    .wrap(dwrap), .err(derr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   ch;
    logic [7:0]   cnt;
    logic [1:0]   prev;
    logic [W-1:0] out;
    logic         valid;
    logic         wrap;
    logic         err;
  } mst_t;

  mst_t ms;

  // Next-state from the written rules, using modulo arithmetic on channels.
  function automatic mst_t model_step(mst_t s, logic [1:0] md, logic [SW-1:0] sl,
                                      logic [7:0] dw, logic ld, logic [CH*W-1:0] d);
    mst_t n = s;
    int   c, nc;
    bit   ok;
    ok      = (int'(sl) < CH);
    c       = (md != s.prev) ? 0 : int'(s.cnt);
    nc      = int'(s.ch);
    n.wrap  = 1'b0;
    n.err   = 1'b0;
    n.valid = 1'b1;
    n.prev  = md;
    if (md == 2'b00) begin
      if (ok) begin nc = int'(sl); c = 0; end
      else n.err = 1'b1;
    end else if (md != 2'b11) begin
      if (ld && ok) begin
        nc = int'(sl); c = 0;
      end else begin
        n.err = ld;
        if (c == int'(dw)) begin
          if (md == 2'b01) begin
            nc     = (int'(s.ch) + 1) % CH;
            n.wrap = (nc == 0);
          end else begin
            nc     = (int'(s.ch) + CH - 1) % CH;
            n.wrap = (s.ch == 0);
          end
          c = 0;
        end else begin
          c = (c + 1) % 256;
        end
      end
    end
    n.ch  = 8'(nc);
    n.cnt = 8'(c);
    if (!(md == 2'b00 && !ok)) n.out = d[nc*W +: W];
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ms <= '0;
    else     ms <= model_step(ms, mode, sel, dwell, load, din);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model ch",    int'(dch),    int'(ms.ch));
      chk("model out",   int'(dout),   int'(ms.out));
      chk("model valid", int'(dvalid), int'(ms.valid));
      chk("model wrap",  int'(dwrap),  int'(ms.wrap));
      chk("model err",   int'(derr),   int'(ms.err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ch"},    int'(dch),    0);
    chk({tag, " out"},   int'(dout),   0);
    chk({tag, " valid"}, int'(dvalid), 0);
    chk({tag, " wrap"},  int'(dwrap),  0);
    chk({tag, " err"},   int'(derr),   0);
  endtask

  int exp_ch[7]   = '{1, 1, 0, 0, 0, 11, 11};
  int exp_wrap[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    mode = 2'b00; sel = '0; dwell = '0; load = 1'b0;
    for (int i = 0; i < CH; i++) din[i*W +: W] = W'(i + 1);

    // Reset applies without a clock edge.
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    cyc(1);
    chk("first valid", int'(dvalid), 1);

    // Manual sweep: channel i holds i+1.
    for (int s = 0; s < CH; s++) begin
      sel = SW'(s);
      cyc(1);
      chk("manual ch",  int'(dch),  s);
      chk("manual out", int'(dout), s + 1);
    end

    // Out-of-range manual select.
    sel = 4'd3;  cyc(1);
    sel = 4'd13; cyc(1);
    chk("bad sel err", int'(derr), 1);
    chk("bad sel ch",  int'(dch),  3);
    chk("bad sel out", int'(dout), 4);
    sel = 4'd3;  cyc(1);
    chk("err clears", int'(derr), 0);

    // Auto-up, dwell 0, load 10: 10,11,0,1 with wrap only on 0.
    mode = 2'b01; dwell = 8'd0; load = 1'b1; sel = 4'd10;
    cyc(1);
    chk("up load ch", int'(dch), 10);
    chk("up load wrap", int'(dwrap), 0);
    load = 1'b0;
    cyc(1); chk("up ch 11", int'(dch), 11);
    cyc(1); chk("up ch 0", int'(dch), 0); chk("up wrap", int'(dwrap), 1);
    cyc(1); chk("up ch 1", int'(dch), 1); chk("up wrap off", int'(dwrap), 0);
    chk("up out", int'(dout), 2);

    // Auto-down, dwell 2, from channel 1.
    mode = 2'b10; dwell = 8'd2; load = 1'b1; sel = 4'd1;
    cyc(1);
    chk("dn load ch", int'(dch), 1);
    load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      chk("dn seq ch",   int'(dch),   exp_ch[k]);
      chk("dn seq wrap", int'(dwrap), exp_wrap[k]);
    end
    chk("dn out", int'(dout), 12);

    // Hold at channel 7 while its data changes, then resume auto-up.
    mode = 2'b01; dwell = 8'd3; load = 1'b1; sel = 4'd7;
    cyc(1);
    load = 1'b0; mode = 2'b11; din[7*W +: W] = 4'hE;
    cyc(1); chk("hold ch", int'(dch), 7); chk("hold out", int'(dout), 14);
    cyc(1);
    din[7*W +: W] = 4'h9;
    cyc(1); chk("hold track", int'(dout), 9);
    cyc(1); chk("hold ch end", int'(dch), 7);
    mode = 2'b01;
    cyc(3); chk("resume dwell", int'(dch), 7);
    cyc(1); chk("resume adv", int'(dch), 8); chk("resume out", int'(dout), 9);

    // Reset in the middle of a dwell count.
    dwell = 8'd5;
    cyc(3);
    #2 rst = 1'b1;
    #1 chk_zero("mid reset");
    #1 rst = 1'b0;
    cyc(1);
    chk("post reset valid", int'(dvalid), 1);
    chk("post reset ch", int'(dch), 0);
    cyc(4); chk("fresh count", int'(dch), 0);
    cyc(1); chk("fresh adv", int'(dch), 1);

    // Out-of-range load in auto mode: err plus normal advance.
    dwell = 8'd0; load = 1'b1; sel = 4'd14;
    cyc(1);
    chk("bad load err", int'(derr), 1);
    chk("bad load adv", int'(dch), 2);
    load = 1'b0;

    // Dwell lowered below the running count.
    dwell = 8'd200; cyc(50);
    dwell = 8'd10;  cyc(260);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      dwell = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                           : 8'($urandom_range(0, 3));
      load  = ($urandom_range(0, 4) == 0);
      sel   = 4'($urandom_range(0, 15));
      din   = 48'({$urandom(), $urandom()});
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 1, bits per data channel.
REQ-002 Parameter CHANNELS, default 16, number of input channels (2..256).
REQ-003 Parameter SEL_W, default 4, select width; SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  CHANNELS*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  manual channel select, and load value.
REQ-008 mode  input  2  00 manual, 01 auto-up, 10 auto-down, 11 hold.
REQ-009 dwell  input  8  extra cycles spent on each channel in auto modes.
REQ-010 load  input  1  in auto modes, load sel into the channel register.
REQ-011 out  output  WIDTH  registered selected channel data.
REQ-012 ch  output  SEL_W  current channel register.
REQ-013 valid  output  1  out holds a post-reset sample.
REQ-014 wrap  output  1  one-cycle pulse on channel wrap-around.
REQ-015 err  output  1  one-cycle pulse on out-of-range select.

Function
REQ-016 Every edge: out <= data_in slice at the next value of ch, giving 1-cycle latency from a channel change to out.
REQ-017 Internal dwell counter dcnt (8 bits) SHALL exist; it is not a port.
REQ-018 Manual mode, sel < CHANNELS: ch <= sel and dcnt <= 0.
REQ-019 Manual mode, sel >= CHANNELS: ch, out and dcnt hold, and err = 1 for one cycle.
REQ-020 Auto-up, dcnt == dwell: ch <= (ch == CHANNELS-1) ? 0 : ch+1, and dcnt <= 0.
REQ-021 Auto-up, dcnt != dwell: dcnt <= dcnt+1 and ch holds.
REQ-022 Auto-down SHALL follow REQ-020/021 with decrement; wrap goes 0 -> CHANNELS-1.
REQ-023 dwell = 0 SHALL advance ch every cycle; dwell = N SHALL advance every N+1 cycles.
REQ-024 wrap = 1 in the cycle after ch is updated across the boundary (CHANNELS-1->0 up, 0->CHANNELS-1 down); 0 otherwise.
REQ-025 load = 1 in auto mode with sel < CHANNELS: ch <= sel and dcnt <= 0; load overrides advance and wrap is not asserted.
REQ-026 load = 1 in auto mode with sel >= CHANNELS: err pulses, and normal advance proceeds.
REQ-027 load SHALL be ignored in manual and hold modes.
REQ-028 Hold mode: ch and dcnt frozen; out continues sampling data_in at ch each cycle.
REQ-029 Any change of mode from the previous cycle SHALL clear dcnt on that edge; ch follows the new mode's rule.
REQ-030 A dwell change mid-count: comparison uses the current dwell; if dcnt > dwell, dcnt counts up to 255, wraps to 0, and then matches.
REQ-031 valid <= 1 on the first clock edge after rst deasserts, then stays 1.

Reset
REQ-032 rst = 1 SHALL immediately, without a clock edge, force ch = 0, dcnt = 0, out = 0, valid = 0, wrap = 0, err = 0, and the previous-mode register = 00.
REQ-033 Reset asserted mid-scan SHALL abandon the dwell count; after release, operation resumes from ch = 0 with a fresh count.

Verification
REQ-034 WIDTH=1, CHANNELS=16, data_in=16'hAAAA, manual, sel stepped 0..15 every 2 cycles -> out = 0,1,0,1,... one cycle after each sel, and ch tracks sel.
REQ-035 Auto-up, dwell=0, load sel=14 -> ch = 14,15,0,1 on successive cycles; wrap = 1 only in the cycle ch = 0 first appears.
REQ-036 Auto-down, dwell=2, from ch=1 -> ch = 1 for 3 cycles, then 0 for 3 cycles, then 15 with wrap pulse; out follows bit ch of 16'hAAAA, 1 cycle late.
REQ-037 WIDTH=4, CHANNELS=12, SEL_W=4: manual sel=3, then sel=13 -> err = 1 for one cycle; ch stays 3 and out stays data_in[15:12].
REQ-038 Auto-up, dwell=5, assert rst mid-count between edges -> all outputs 0 immediately; after release, valid = 1 on the first edge and ch advances to 1 after 6 cycles.
REQ-039 Auto-up at ch=7, switch to hold for 4 cycles while data_in changes -> ch stays 7, out tracks the new data_in[7], and dcnt restarts from 0 on return to auto.
